// File: rtl/regfile_64_checker.sv
// Response monitor for the 64-bit hot/cold register file: shadows all 32 registers,
// predicts read data and the cold-access error flag, and records every mismatch.
module regfile_64_checker #(
   parameter logic [31:0] COLD_MASK = 32'hFFFF_FA98,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_en,
   input  logic             dut_rst_n,
   input  logic [4:0]       raddr_i_1,
   input  logic [4:0]       raddr_i_2,
   input  logic [4:0]       waddr_i_1,
   input  logic [63:0]      wdata,
   input  logic             regwrite,
   input  logic             is_16_i,
   input  logic             cold_en_i,
   input  logic [63:0]      rdata_o_1,
   input  logic [63:0]      rdata_o_2,
   input  logic             cold_en_err_o,
   output logic             mismatch_o,
   output logic             err_sticky_o,
   output logic [CNT_W-1:0] err_count_o,
   output logic [31:0]      check_count_o,
   output logic [1:0]       ff_code_o,
   output logic [4:0]       ff_addr_o,
   output logic [63:0]      ff_exp_o,
   output logic [63:0]      ff_got_o
);

   typedef enum logic [1:0] {
      FF_NONE  = 2'd0,
      FF_PORT1 = 2'd1,
      FF_PORT2 = 2'd2,
      FF_ERR   = 2'd3
   } ff_code_t;

   localparam logic [CNT_W-1:0] ERR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [63:0] shadow [32];

   logic [4:0]  eff_r1, eff_r2, eff_w;
   logic        unauth_r1, unauth_r2, unauth_w;
   logic        exp_err, wr_ok, compare;
   logic [63:0] exp_d1, exp_d2;
   logic        fail_1, fail_2, fail_err, fail_any;

   ff_code_t    ff_sel_code, ff_code_q;
   logic [4:0]  ff_sel_addr;
   logic [63:0] ff_sel_exp, ff_sel_got;

   // Prediction of this cycle's responses from the pre-edge shadow (no write bypass).
   always_comb begin
      eff_r1    = is_16_i ? {2'b01, raddr_i_1[2:0]} : raddr_i_1;
      eff_r2    = raddr_i_2;
      eff_w     = is_16_i ? {2'b01, waddr_i_1[2:0]} : waddr_i_1;
      unauth_r1 = COLD_MASK[eff_r1] && !cold_en_i;
      unauth_r2 = COLD_MASK[eff_r2] && !cold_en_i;
      unauth_w  = regwrite && COLD_MASK[eff_w] && !cold_en_i;
      exp_err   = unauth_r1 || unauth_r2 || unauth_w;
      wr_ok     = regwrite && (eff_w != 5'd0) && !unauth_w;
      exp_d1    = (eff_r1 == 5'd0 || unauth_r1) ? 64'd0 : shadow[eff_r1];
      exp_d2    = (eff_r2 == 5'd0 || unauth_r2) ? 64'd0 : shadow[eff_r2];
      compare   = chk_en && dut_rst_n;
      fail_1    = rdata_o_1 != exp_d1;
      fail_2    = rdata_o_2 != exp_d2;
      fail_err  = cold_en_err_o != exp_err;
      fail_any  = fail_1 || fail_2 || fail_err;
   end

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      ff_sel_code = FF_ERR;
      ff_sel_addr = 5'd0;
      ff_sel_exp  = {63'd0, exp_err};
      ff_sel_got  = {63'd0, cold_en_err_o};
      if (fail_1) begin
         ff_sel_code = FF_PORT1;
         ff_sel_addr = eff_r1;
         ff_sel_exp  = exp_d1;
         ff_sel_got  = rdata_o_1;
      end else if (fail_2) begin
         ff_sel_code = FF_PORT2;
         ff_sel_addr = eff_r2;
         ff_sel_exp  = exp_d2;
         ff_sel_got  = rdata_o_2;
      end
   end

   // NOTE: the shadow must start at zero to match the register file, so this array is reset, unlike a plain RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) shadow[i] <= '0;
      end else if (!dut_rst_n) begin
         for (int i = 0; i < 32; i++) shadow[i] <= '0;
      end else if (wr_ok) begin
         shadow[eff_w] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch_o    <= 1'b0;
         err_sticky_o  <= 1'b0;
         err_count_o   <= '0;
         check_count_o <= '0;
         ff_code_q     <= FF_NONE;
         ff_addr_o     <= '0;
         ff_exp_o      <= '0;
         ff_got_o      <= '0;
      end else begin
         mismatch_o <= compare && fail_any;
         if (compare) begin
            if (check_count_o != 32'hFFFF_FFFF) check_count_o <= check_count_o + 32'd1;
            if (fail_any) begin
               err_sticky_o <= 1'b1;
               if (err_count_o != {CNT_W{1'b1}}) err_count_o <= err_count_o + ERR_ONE;
               // The sticky flag doubles as the capture arm: only the first failure since rst loads.
               if (!err_sticky_o) begin
                  ff_code_q <= ff_sel_code;
                  ff_addr_o <= ff_sel_addr;
                  ff_exp_o  <= ff_sel_exp;
                  ff_got_o  <= ff_sel_got;
               end
            end
         end
      end
   end

   assign ff_code_o = ff_code_q;

endmodule

// File: tb/tb_regfile_64_checker.sv
// Bench for regfile_64_checker: directed vector table, random run against an array model,
// counter saturation and asynchronous reset sequences.
module tb_regfile_64_checker;

   localparam logic [31:0] COLD_MASK = 32'hFFFF_FA98;
   localparam int CNT_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst;
   logic        chk_en, dut_rst_n;
   logic [4:0]  raddr_i_1, raddr_i_2, waddr_i_1;
   logic [63:0] wdata;
   logic        regwrite, is_16_i, cold_en_i;
   logic [63:0] rdata_o_1, rdata_o_2;
   logic        cold_en_err_o;
   logic        mismatch_o, err_sticky_o;
   logic [15:0] err_count_o;
   logic [31:0] check_count_o;
   logic [1:0]  ff_code_o;
   logic [4:0]  ff_addr_o;
   logic [63:0] ff_exp_o, ff_got_o;

   int total = 0;
   int bad   = 0;

   regfile_64_checker #(.COLD_MASK(COLD_MASK), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .chk_en(chk_en), .dut_rst_n(dut_rst_n),
      .raddr_i_1(raddr_i_1), .raddr_i_2(raddr_i_2), .waddr_i_1(waddr_i_1),
      .wdata(wdata), .regwrite(regwrite), .is_16_i(is_16_i), .cold_en_i(cold_en_i),
      .rdata_o_1(rdata_o_1), .rdata_o_2(rdata_o_2), .cold_en_err_o(cold_en_err_o),
      .mismatch_o(mismatch_o), .err_sticky_o(err_sticky_o), .err_count_o(err_count_o),
      .check_count_o(check_count_o), .ff_code_o(ff_code_o), .ff_addr_o(ff_addr_o),
      .ff_exp_o(ff_exp_o), .ff_got_o(ff_got_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        rst_before, regwrite, is16, cold_en, chk_en, drst;
      logic [4:0]  waddr, r1, r2;
      logic [63:0] wdata, rd1, rd2;
      logic        err;
      logic        exp_mm;
      int          exp_cnt, exp_chk;
      logic [1:0]  exp_code;
      logic [4:0]  exp_addr;
      logic [63:0] exp_exp, exp_got;
   } vec_t;

   function automatic vec_t mk(logic rb, logic wr, logic [4:0] wa, logic [63:0] wd,
                               logic [4:0] r1, logic [4:0] r2, logic is16, logic ce,
                               logic ck, logic dr, logic [63:0] rd1, logic [63:0] rd2,
                               logic er, logic mm, int cnt, int chk, logic [1:0] code,
                               logic [4:0] addr, logic [63:0] fe, logic [63:0] fg);
      vec_t v;
      v.rst_before = rb; v.regwrite = wr; v.waddr = wa; v.wdata = wd;
      v.r1 = r1; v.r2 = r2; v.is16 = is16; v.cold_en = ce; v.chk_en = ck; v.drst = dr;
      v.rd1 = rd1; v.rd2 = rd2; v.err = er;
      v.exp_mm = mm; v.exp_cnt = cnt; v.exp_chk = chk; v.exp_code = code;
      v.exp_addr = addr; v.exp_exp = fe; v.exp_got = fg;
      return v;
   endfunction

   // ---------------- behavioural model ----------------
   logic [63:0] m_sh [32];
   bit          m_mm, m_sticky;
   int          m_cnt;
   longint      m_chk;
   logic [1:0]  m_code;
   logic [4:0]  m_addr;
   logic [63:0] m_exp, m_got;

   function automatic bit is_cold(int a);
      return COLD_MASK[a] == 1'b1;
   endfunction

   function automatic int map_addr(logic [4:0] a, bit mapped);
      return (mapped && is_16_i) ? 8 + (int'(a) % 8) : int'(a);
   endfunction

   function automatic bit unauth(int a);
      return is_cold(a) && !cold_en_i;
   endfunction

   function automatic logic [63:0] model_read(int a);
      return (a == 0 || unauth(a)) ? 64'd0 : m_sh[a];
   endfunction

   function automatic bit model_err();
      return unauth(map_addr(raddr_i_1, 1)) || unauth(map_addr(raddr_i_2, 0)) ||
             (regwrite && unauth(map_addr(waddr_i_1, 1)));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_sh[i] = '0;
      m_mm = 0; m_sticky = 0; m_cnt = 0; m_chk = 0;
      m_code = 0; m_addr = 0; m_exp = 0; m_got = 0;
   endtask

   // Applies the rules for one edge using the inputs present just before it.
   task automatic model_step();
      int a1, a2, aw;
      logic [63:0] x1, x2;
      bit xe;
      a1 = map_addr(raddr_i_1, 1);
      a2 = map_addr(raddr_i_2, 0);
      aw = map_addr(waddr_i_1, 1);
      m_mm = 0;
      if (!dut_rst_n) begin
         for (int i = 0; i < 32; i++) m_sh[i] = '0;
         return;
      end
      x1 = model_read(a1);
      x2 = model_read(a2);
      xe = model_err();
      if (chk_en) begin
         if (rdata_o_1 !== x1 || rdata_o_2 !== x2 || cold_en_err_o !== xe) begin
            m_mm = 1;
            if (!m_sticky) begin
               if (rdata_o_1 !== x1) begin
                  m_code = 1; m_addr = 5'(a1); m_exp = x1; m_got = rdata_o_1;
               end else if (rdata_o_2 !== x2) begin
                  m_code = 2; m_addr = 5'(a2); m_exp = x2; m_got = rdata_o_2;
               end else begin
                  m_code = 3; m_addr = 0; m_exp = {63'd0, xe}; m_got = {63'd0, cold_en_err_o};
               end
            end
            m_sticky = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
         if (m_chk < 64'hFFFF_FFFF) m_chk++;
      end
      if (regwrite && aw != 0 && !unauth(aw)) m_sh[aw] = wdata;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".mismatch"}, 64'(mismatch_o), 64'(m_mm));
      check({tag, ".sticky"}, 64'(err_sticky_o), 64'(m_sticky));
      check({tag, ".err_count"}, 64'(err_count_o), 64'(m_cnt));
      check({tag, ".check_count"}, 64'(check_count_o), 64'(m_chk));
      check({tag, ".ff_code"}, 64'(ff_code_o), 64'(m_code));
      check({tag, ".ff_addr"}, 64'(ff_addr_o), 64'(m_addr));
      check({tag, ".ff_exp"}, ff_exp_o, m_exp);
      check({tag, ".ff_got"}, ff_got_o, m_got);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic idle_inputs();
      chk_en = 1; dut_rst_n = 1; raddr_i_1 = 0; raddr_i_2 = 0; waddr_i_1 = 0;
      wdata = 0; regwrite = 0; is_16_i = 0; cold_en_i = 0;
      rdata_o_1 = 0; rdata_o_2 = 0; cold_en_err_o = 0;
   endtask

   vec_t vecs[16];

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      check("reset.mismatch", 64'(mismatch_o), 64'd0);
      check("reset.err_count", 64'(err_count_o), 64'd0);
      check("reset.ff_code", 64'(ff_code_o), 64'd0);
      #1 rst = 1'b0;

      //            rb wr wa  wdata                  r1 r2 16 ce ck dr rd1                    rd2                    er mm cnt chk code addr exp                   got
      vecs[0]  = mk(1, 1, 1, 64'h123456789ABCDEF0, 0, 0, 0, 0, 1, 1, 64'h0,                 64'h0,                 0, 0, 0, 1, 0, 0, 64'h0,                 64'h0);
      vecs[1]  = mk(0, 0, 0, 64'h0,                 1, 1, 0, 0, 1, 1, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 0, 0, 0, 2, 0, 0, 64'h0,                 64'h0);
      vecs[2]  = mk(1, 1, 3, 64'hABCDEF0123456789, 0, 0, 0, 0, 1, 1, 64'h0,                 64'h0,                 0, 1, 1, 1, 3, 0, 64'h1,                 64'h0);
      vecs[3]  = mk(0, 0, 0, 64'h0,                 3, 3, 0, 1, 1, 1, 64'h0,                 64'h0,                 0, 0, 1, 2, 3, 0, 64'h1,                 64'h0);
      vecs[4]  = mk(1, 1, 0, 64'hABABABABABABABAB, 0, 0, 1, 0, 1, 1, 64'h0,                 64'h0,                 0, 0, 0, 1, 0, 0, 64'h0,                 64'h0);
      vecs[5]  = mk(0, 0, 0, 64'h0,                 0, 8, 1, 0, 1, 1, 64'hABABABABABABABAB, 64'h0,                 0, 1, 1, 2, 2, 8, 64'hABABABABABABABAB, 64'h0);
      vecs[6]  = mk(1, 1, 6, 64'hE1E2E3E4F1F2F3F4, 6, 0, 0, 0, 1, 1, 64'h0,                 64'h0,                 0, 0, 0, 1, 0, 0, 64'h0,                 64'h0);
      vecs[7]  = mk(0, 0, 0, 64'h0,                 6, 6, 0, 0, 1, 1, 64'hE1E2E3E4F1F2F3F4, 64'hE1E2E3E4F1F2F3F4, 0, 0, 0, 2, 0, 0, 64'h0,                 64'h0);
      vecs[8]  = mk(1, 1, 1, 64'h1111,              0, 0, 0, 0, 1, 1, 64'h0,                 64'h0,                 0, 0, 0, 1, 0, 0, 64'h0,                 64'h0);
      vecs[9]  = mk(0, 1, 3, 64'h3333,              0, 0, 0, 1, 1, 1, 64'h0,                 64'h0,                 0, 0, 0, 2, 0, 0, 64'h0,                 64'h0);
      vecs[10] = mk(0, 0, 0, 64'h0,                 1, 0, 0, 0, 1, 0, 64'hFFFF,              64'h0,                 1, 0, 0, 2, 0, 0, 64'h0,                 64'h0);
      vecs[11] = mk(0, 0, 0, 64'h0,                 1, 3, 0, 1, 1, 1, 64'h0,                 64'h0,                 0, 0, 0, 3, 0, 0, 64'h0,                 64'h0);
      vecs[12] = mk(0, 0, 0, 64'h0,                 1, 0, 0, 0, 1, 1, 64'h1111,              64'h0,                 0, 1, 1, 4, 1, 1, 64'h0,                 64'h1111);
      vecs[13] = mk(0, 1, 2, 64'h2222,              1, 0, 0, 0, 0, 1, 64'hDEAD,              64'h0,                 1, 0, 1, 4, 1, 1, 64'h0,                 64'h1111);
      vecs[14] = mk(0, 0, 0, 64'h0,                 2, 4, 0, 0, 1, 1, 64'h2222,              64'h0,                 1, 0, 1, 5, 1, 1, 64'h0,                 64'h1111);
      vecs[15] = mk(0, 0, 0, 64'h0,                 4, 0, 0, 0, 1, 1, 64'h0,                 64'h0,                 0, 1, 2, 6, 1, 1, 64'h0,                 64'h1111);

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rst_before) pulse_rst();
         regwrite = vecs[i].regwrite; waddr_i_1 = vecs[i].waddr; wdata = vecs[i].wdata;
         raddr_i_1 = vecs[i].r1; raddr_i_2 = vecs[i].r2; is_16_i = vecs[i].is16;
         cold_en_i = vecs[i].cold_en; chk_en = vecs[i].chk_en; dut_rst_n = vecs[i].drst;
         rdata_o_1 = vecs[i].rd1; rdata_o_2 = vecs[i].rd2; cold_en_err_o = vecs[i].err;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d.mismatch", i), 64'(mismatch_o), 64'(vecs[i].exp_mm));
         check($sformatf("vec%0d.sticky", i), 64'(err_sticky_o), 64'(vecs[i].exp_cnt != 0));
         check($sformatf("vec%0d.err_count", i), 64'(err_count_o), 64'(vecs[i].exp_cnt));
         check($sformatf("vec%0d.check_count", i), 64'(check_count_o), 64'(vecs[i].exp_chk));
         check($sformatf("vec%0d.ff_code", i), 64'(ff_code_o), 64'(vecs[i].exp_code));
         check($sformatf("vec%0d.ff_addr", i), 64'(ff_addr_o), 64'(vecs[i].exp_addr));
         check($sformatf("vec%0d.ff_exp", i), ff_exp_o, vecs[i].exp_exp);
         check($sformatf("vec%0d.ff_got", i), ff_got_o, vecs[i].exp_got);
      end

      // Random run: the bench plays the register file, usually answering correctly.
      idle_inputs();
      pulse_rst();
      model_reset();
      for (int i = 0; i < 600; i++) begin
         regwrite  = 1'($urandom_range(0, 1));
         waddr_i_1 = 5'($urandom);
         wdata     = {$urandom, $urandom};
         raddr_i_1 = 5'($urandom);
         raddr_i_2 = 5'($urandom);
         is_16_i   = ($urandom_range(0, 3) == 0);
         cold_en_i = 1'($urandom_range(0, 1));
         chk_en    = ($urandom_range(0, 7) != 0);
         dut_rst_n = ($urandom_range(0, 31) != 0);
         rdata_o_1 = model_read(map_addr(raddr_i_1, 1));
         rdata_o_2 = model_read(map_addr(raddr_i_2, 0));
         cold_en_err_o = model_err();
         if ($urandom_range(0, 15) == 0) rdata_o_1 ^= 64'd1 << $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) rdata_o_2 ^= 64'd1 << $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) cold_en_err_o = ~cold_en_err_o;
         if ($urandom_range(0, 149) == 0) begin
            pulse_rst();
            model_reset();
         end
         @(posedge clk);
         #1;
         model_step();
         check_model($sformatf("rand%0d", i));
      end

      // Saturation: port 1 reads x0 but sees 1 on every compared cycle.
      idle_inputs();
      pulse_rst();
      rdata_o_1 = 64'h1;
      repeat (70000) @(posedge clk);
      #1;
      check("sat.err_count", 64'(err_count_o), 64'hFFFF);
      check("sat.sticky", 64'(err_sticky_o), 64'd1);
      check("sat.mismatch", 64'(mismatch_o), 64'd1);
      check("sat.check_count", 64'(check_count_o), 64'd70000);
      check("sat.ff_code", 64'(ff_code_o), 64'd1);
      check("sat.ff_got", ff_got_o, 64'h1);

      // Asynchronous clear between edges, then the first edge after release samples normally.
      #2 rst = 1'b1;
      #1;
      check("arst.mismatch", 64'(mismatch_o), 64'd0);
      check("arst.sticky", 64'(err_sticky_o), 64'd0);
      check("arst.err_count", 64'(err_count_o), 64'd0);
      check("arst.check_count", 64'(check_count_o), 64'd0);
      check("arst.ff_code", 64'(ff_code_o), 64'd0);
      check("arst.ff_got", ff_got_o, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst.mismatch", 64'(mismatch_o), 64'd1);
      check("post_rst.err_count", 64'(err_count_o), 64'd1);
      check("post_rst.check_count", 64'(check_count_o), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_64_checker.md
# regfile_64_checker

Self-checking response monitor for the 64-bit hot/cold register file. It sits on the register file's port bundle, alongside the stimulus generator, and observes every write and read request plus the register file's read data and cold-access error flag. It keeps a shadow copy of all 32 registers and compares each cycle's observed responses against the expected values. Mismatches are reported as a pulse, a sticky flag, saturating counters and a first-failure capture.

## Interface
Parameters:
- COLD_MASK, 32'hFFFF_FA98, bit n set means xn is a cold register (default: hot = x0,x1,x2,x5,x6,x8,x10).
- CNT_W, 16, width of err_count_o.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- chk_en  in  1  comparison enable.
- dut_rst_n  in  1  observed register-file reset (active low).
- raddr_i_1, raddr_i_2  in  5  observed read addresses.
- waddr_i_1  in  5  observed write address.
- wdata  in  64  observed write data.
- regwrite  in  1  observed write strobe.
- is_16_i  in  1  observed 16-bit instruction mode.
- cold_en_i  in  1  observed cold-access authorization.
- rdata_o_1, rdata_o_2  in  64  observed register-file read data.
- cold_en_err_o  in  1  observed register-file error flag.
- mismatch_o  out  1  one-cycle pulse per failing cycle.
- err_sticky_o  out  1  set on the first mismatch; cleared only by rst.
- err_count_o  out  CNT_W  failing cycles, saturating at all-ones.
- check_count_o  out  32  compared cycles, saturating.
- ff_code_o  out  2  first-failure type: 0 none, 1 port-1 data, 2 port-2 data, 3 error flag.
- ff_addr_o  out  5  effective address of the first failure (0 when the type is the error flag).
- ff_exp_o, ff_got_o  out  64  expected and observed values at the first failure (bit 0 only for the error flag).

## Operation
Address mapping:
- When is_16_i=1, raddr_i_1 and waddr_i_1 map to the effective register {2'b01, addr[2:0]}, i.e. x8–x15.
- raddr_i_2 is never mapped.
- When is_16_i=0, addresses are used as given.

Authorization and expected error:
- An access is unauthorized when its effective address is cold and cold_en_i=0.
- Both read ports are treated as active every cycle.
- The write port is active only when regwrite=1.
- Expected cold_en_err = OR of unauthorized conditions over all active ports.

Expected read data:
- Effective address 0 returns 0.
- An unauthorized read returns 0.
- Otherwise the read returns the shadow entry as it stood before this cycle's write. There is no write-to-read bypass.

Shadow update at each edge:
- If regwrite=1, the effective write address is not 0, and the write is authorized, store wdata in the shadow entry.
- Otherwise the shadow is unchanged.

Comparison:
- A cycle is compared only when chk_en=1 and dut_rst_n=1.
- Three checks are made: port-1 data, port-2 data, and the error flag.
- Any failing check marks the cycle as failing.

First-failure capture:
- Loaded only on the first failing cycle after rst.
- Priority: port 1, then port 2, then the error flag.

Register-file reset tracking:
- When dut_rst_n=0 at an edge, all 32 shadow entries clear to 0 and no compare or write occurs.
- Counters, the sticky flag and the capture registers are retained.

Reset values under rst:
- Shadow cleared to 0.
- All outputs are 0.
- The first-failure capture is re-armed.

## Timing
- The sample/compare occurs at edge k, using the values present just before it.
- mismatch_o is high for the cycle following edge k (registered), exactly one cycle per failing cycle.
- err_sticky_o and err_count_o update in the same cycle as mismatch_o.
- The ff_* outputs are valid in the same cycle as mismatch_o and hold afterwards.
- check_count_o increments one cycle after each compared edge.
- err_count_o saturates at 2^CNT_W−1; check_count_o saturates at 2^32−1.
- Simultaneous write and read to the same effective address: reads are checked against the old value, and the new value is visible from the next cycle.
- rst asserted mid-run clears everything asynchronously. The first edge after rst is released is a normal sample.
- chk_en=0: the shadow still tracks writes; no counters change.

## Test plan
- Write x1=64'h123456789ABCDEF0, then read x1 on both ports with correct data -> mismatch_o stays 0 and check_count_o increments by 1 per cycle.
- Cold write x3=64'hABCDEF0123456789 with cold_en_i=0, then an error-free read -> ff_code_o=3, ff_exp_o=1, ff_got_o=0, err_count_o=1; the shadow x3 stays 0.
- is_16_i=1: write waddr_i_1=0 with 64'hABABABABABABABAB; read raddr_i_1=0 and raddr_i_2=8 with rdata_o_2 forced to 0 -> ff_code_o=2, ff_addr_o=8, ff_exp_o=64'hABABABABABABABAB.
- Same-cycle write x6=64'hE1E2E3E4F1F2F3F4 while reading x6 on port 1 with the old value 0 -> no mismatch; the next-cycle read of x6 expects the new value.
- Pulse dut_rst_n low for one cycle after loading x1 and x3 -> subsequent reads expect 0; no compare occurs in the reset cycle.
- Force 70000 failing cycles with CNT_W=16 -> err_count_o=16'hFFFF, err_sticky_o=1; asserting rst clears all outputs to 0.
